// File: rtl/lock_pkg.sv
// ============================================================================
// Module      : lock_pkg
// Description : Key codes, debounce states and keypad position-to-code map
// Revision    : 1.0
// ============================================================================
`default_nettype none

package lock_pkg;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CONFIRM   = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_RELEASING = 2'd3
    } db_state_t;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_SINGLE = 2'd1,
        CLS_MULTI  = 2'd2
    } snap_class_t;

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = KEY_0;
        case ({row, col})
            4'd0:  code = KEY_1;
            4'd1:  code = KEY_2;
            4'd2:  code = KEY_3;
            4'd3:  code = KEY_A;
            4'd4:  code = KEY_4;
            4'd5:  code = KEY_5;
            4'd6:  code = KEY_6;
            4'd7:  code = KEY_B;
            4'd8:  code = KEY_7;
            4'd9:  code = KEY_8;
            4'd10: code = KEY_9;
            4'd11: code = KEY_C;
            4'd12: code = KEY_STAR;
            4'd13: code = KEY_0;
            4'd14: code = KEY_HASH;
            4'd15: code = KEY_D;
            default: code = KEY_0;
        endcase
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_col_scan.sv
// ============================================================================
// Module      : keypad_col_scan
// Description : Column sequencer, row synchroniser, snapshot assembly and
//               per-scan classification (none / single key / multiple keys)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module keypad_col_scan
    import lock_pkg::*;
#(
    parameter int SCAN_CYCLES = 4
)
(
    input  logic        hwclk,
    input  logic        rst_n,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic        snap_valid,
    output snap_class_t snap_class,
    output logic [3:0]  key_idx,
    output logic [15:0] snapshot
);

    localparam int               CYC_W    = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SCAN_CYCLES - 1);

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [1:0]       r_slot;
    logic [CYC_W-1:0] r_cyc;
    logic [15:0]      r_snap;
    logic             r_cls_pend;

    logic             w_slot_end;
    logic [4:0]       w_count;
    logic [3:0]       w_idx;

    assign w_slot_end = (r_cyc == CYC_LAST);
    assign col_n      = ~(4'b0001 << r_slot);

    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            r_sync1    <= 4'hF;
            r_sync2    <= 4'hF;
            r_slot     <= 2'd0;
            r_cyc      <= '0;
            r_snap     <= 16'h0000;
            r_cls_pend <= 1'b0;
        end else begin
            r_sync1    <= row_n;
            r_sync2    <= r_sync1;
            r_cls_pend <= w_slot_end && (r_slot == 2'd3);
            if (w_slot_end) begin
                r_cyc  <= '0;
                r_slot <= r_slot + 2'd1;
                // Each slot rewrites only its own column, so no clear is needed between scans
                for (int r = 0; r < 4; r++) begin
                    r_snap[4*r + int'(r_slot)] <= ~r_sync2[r];
                end
            end else begin
                r_cyc <= r_cyc + 1'b1;
            end
        end
    end

    always_comb begin
        w_count = 5'd0;
        w_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (r_snap[i]) begin
                w_count = w_count + 5'd1;
                w_idx   = 4'(i);
            end
        end
    end

    always_comb begin
        snap_class = CLS_MULTI;
        if (w_count == 5'd0) begin
            snap_class = CLS_NONE;
        end else if (w_count == 5'd1) begin
            snap_class = CLS_SINGLE;
        end
    end

    assign snap_valid = r_cls_pend;
    assign key_idx    = w_idx;
    assign snapshot   = r_snap;

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 keypad front-end: debounce FSM over full-scan snapshots,
//               holding the last accepted key code and a press-level strobe
// Revision    : 1.0
// ============================================================================
`default_nettype none

module keypad_scanner
    import lock_pkg::*;
#(
    parameter int SCAN_CYCLES    = 4,
    parameter int DEBOUNCE_SCANS = 3
)
(
    input  logic       hwclk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] button,
    output logic       bstate,
    output logic       key_press,
    output logic       key_release
);

    localparam int               CNT_W     = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic        w_snap_valid;
    snap_class_t w_class;
    logic [3:0]  w_key_idx;
    logic [15:0] w_snapshot;

    db_state_t        r_state;
    db_state_t        w_state_nxt;
    logic [3:0]       r_cand;
    logic [3:0]       w_cand_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [3:0]       r_button;
    logic [3:0]       w_button_nxt;
    logic             r_bstate;
    logic             w_bstate_nxt;
    logic             r_press;
    logic             w_press_nxt;
    logic             r_release;
    logic             w_release_nxt;
    logic             w_cand_hit;

    keypad_col_scan #(
        .SCAN_CYCLES (SCAN_CYCLES)
    ) u_col_scan (
        .hwclk      (hwclk),
        .rst_n      (rst_n),
        .row_n      (row_n),
        .col_n      (col_n),
        .snap_valid (w_snap_valid),
        .snap_class (w_class),
        .key_idx    (w_key_idx),
        .snapshot   (w_snapshot)
    );

    assign w_cnt_inc  = r_cnt + CNT_ONE;
    assign w_cand_hit = w_snapshot[r_cand];

    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cand    <= 4'd0;
            r_cnt     <= '0;
            r_button  <= 4'd0;
            r_bstate  <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cand    <= w_cand_nxt;
            r_cnt     <= w_cnt_nxt;
            r_button  <= w_button_nxt;
            r_bstate  <= w_bstate_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cand_nxt    = r_cand;
        w_cnt_nxt     = r_cnt;
        w_button_nxt  = r_button;
        w_bstate_nxt  = r_bstate;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;

        if (w_snap_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_class == CLS_SINGLE) begin
                        w_cand_nxt = w_key_idx;
                        if (DEBOUNCE_SCANS == 1) begin
                            w_state_nxt  = ST_PRESSED;
                            w_cnt_nxt    = '0;
                            w_button_nxt = key_code(w_key_idx[3:2], w_key_idx[1:0]);
                            w_bstate_nxt = 1'b1;
                            w_press_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = ST_CONFIRM;
                            w_cnt_nxt   = CNT_ONE;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if ((w_class == CLS_SINGLE) && (w_key_idx == r_cand)) begin
                        if (w_cnt_inc == CNT_LIMIT) begin
                            w_state_nxt  = ST_PRESSED;
                            w_cnt_nxt    = '0;
                            w_button_nxt = key_code(r_cand[3:2], r_cand[1:0]);
                            w_bstate_nxt = 1'b1;
                            w_press_nxt  = 1'b1;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_PRESSED: begin
                    // Only the held key's own bit matters, so a second key cannot displace it
                    if (!w_cand_hit) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            w_state_nxt   = ST_IDLE;
                            w_cnt_nxt     = '0;
                            w_bstate_nxt  = 1'b0;
                            w_release_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_RELEASING;
                            w_cnt_nxt   = CNT_ONE;
                        end
                    end
                end
                ST_RELEASING: begin
                    if (!w_cand_hit) begin
                        if (w_cnt_inc == CNT_LIMIT) begin
                            w_state_nxt   = ST_IDLE;
                            w_cnt_nxt     = '0;
                            w_bstate_nxt  = 1'b0;
                            w_release_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        w_state_nxt = ST_PRESSED;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign button      = r_button;
    assign bstate      = r_bstate;
    assign key_press   = r_press;
    assign key_release = r_release;

endmodule

`default_nettype wire
